// File: rtl/glbl_reg_arb_pkg.sv
// Shared types and constants for the global config register bus arbiter.
//   state_e           : arbiter sequencing states
//   reg_cmd_t         : one latched register-bus command (wr/addr/wdata/be)
//   ERR_RDATA_DEFAULT : read data returned on a timed-out access
package glbl_reg_arb_pkg;

   localparam int unsigned NUM_MASTERS = 2;
   localparam int unsigned GNT_W       = $clog2(NUM_MASTERS);
   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } reg_cmd_t;

endpackage

// File: rtl/glbl_reg_arb.sv
// Two-master round-robin arbiter/sequencer for the global config register bus.
// Master 0 (host bridge) and master 1 (debug port) share one reg_cs/reg_ack
// slave port. Each access is latched at grant, held stable while BUSY, and
// answered with a one-cycle ack (plus err on timeout) in RESP.
// Ports:
//   mclk, reset          : clock, synchronous active-high reset
//   mN_reg_cs/wr/addr/   : master N request and command (N = 0, 1)
//   wdata/be
//   mN_reg_rdata/ack/err : master N response, valid only in the ack cycle
//   reg_cs/wr/addr/      : slave command, registered
//   wdata/be
//   reg_rdata, reg_ack   : slave response
module glbl_reg_arb
   import glbl_reg_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              m0_reg_cs,
   input  logic              m0_reg_wr,
   input  logic [ADDR_W-1:0] m0_reg_addr,
   input  logic [DATA_W-1:0] m0_reg_wdata,
   input  logic [BE_W-1:0]   m0_reg_be,
   output logic [DATA_W-1:0] m0_reg_rdata,
   output logic              m0_reg_ack,
   output logic              m0_reg_err,
   input  logic              m1_reg_cs,
   input  logic              m1_reg_wr,
   input  logic [ADDR_W-1:0] m1_reg_addr,
   input  logic [DATA_W-1:0] m1_reg_wdata,
   input  logic [BE_W-1:0]   m1_reg_be,
   output logic [DATA_W-1:0] m1_reg_rdata,
   output logic              m1_reg_ack,
   output logic              m1_reg_err,
   output logic              reg_cs,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic [BE_W-1:0]   reg_be,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic              reg_ack
);

   // Counter is cleared on every BUSY exit, so it never needs to reach TIMEOUT_CYCLES.
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q;
   logic [GNT_W-1:0]  last_grant_q;
   logic [GNT_W-1:0]  grant_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [GNT_W-1:0]  grant_d;
   reg_cmd_t          m0_cmd;
   reg_cmd_t          m1_cmd;
   reg_cmd_t          sel_cmd;
   logic              timeout_hit;
   logic              done;
   logic              resp_err;
   logic [DATA_W-1:0] resp_data;
   logic              to_m0;

   assign m0_cmd = {m0_reg_wr, m0_reg_addr, m0_reg_wdata, m0_reg_be};
   assign m1_cmd = {m1_reg_wr, m1_reg_addr, m1_reg_wdata, m1_reg_be};

   // Round-robin pick: on a tie the master that did not win last time goes.
   always_comb begin
      grant_d = GNT_W'(m1_reg_cs);
      if (m0_reg_cs && m1_reg_cs) begin
         grant_d = ~last_grant_q;
      end
   end

   assign sel_cmd = (grant_d == GNT_W'(1)) ? m1_cmd : m0_cmd;

   // Slave ack takes priority over a timeout landing on the same cycle.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign done        = reg_ack || timeout_hit;
   assign resp_err    = ~reg_ack;
   assign resp_data   = reg_ack ? reg_rdata : ERR_RDATA;
   assign to_m0       = (grant_q == GNT_W'(0));

   // Sequencer: IDLE -> BUSY (slave access) -> RESP (master ack) -> IDLE.
   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_W'(1);
         grant_q      <= '0;
         cnt_q        <= '0;
         reg_cs       <= 1'b0;
         reg_wr       <= 1'b0;
         reg_addr     <= '0;
         reg_wdata    <= '0;
         reg_be       <= '0;
         m0_reg_ack   <= 1'b0;
         m0_reg_err   <= 1'b0;
         m0_reg_rdata <= '0;
         m1_reg_ack   <= 1'b0;
         m1_reg_err   <= 1'b0;
         m1_reg_rdata <= '0;
      end else begin
         // Responses are single-cycle pulses.
         m0_reg_ack   <= 1'b0;
         m0_reg_err   <= 1'b0;
         m0_reg_rdata <= '0;
         m1_reg_ack   <= 1'b0;
         m1_reg_err   <= 1'b0;
         m1_reg_rdata <= '0;

         unique case (state_q)
            IDLE: begin
               if (m0_reg_cs || m1_reg_cs) begin
                  grant_q      <= grant_d;
                  last_grant_q <= grant_d;
                  {reg_wr, reg_addr, reg_wdata, reg_be} <= sel_cmd;
                  reg_cs       <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  reg_cs       <= 1'b0;
                  cnt_q        <= '0;
                  state_q      <= RESP;
                  m0_reg_ack   <= to_m0;
                  m0_reg_err   <= to_m0 & resp_err;
                  m0_reg_rdata <= to_m0 ? resp_data : '0;
                  m1_reg_ack   <= ~to_m0;
                  m1_reg_err   <= ~to_m0 & resp_err;
                  m1_reg_rdata <= to_m0 ? '0 : resp_data;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glbl_reg_arb.sv
// Self-checking bench for glbl_reg_arb: directed steps plus randomized
// accesses, compared against a transaction-level arbitration/timeout model.
module tb_glbl_reg_arb;

   localparam int unsigned T = 4;
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic        mclk = 1'b0;
   logic        reset;
   logic        m0_reg_cs, m0_reg_wr, m1_reg_cs, m1_reg_wr;
   logic [7:0]  m0_reg_addr, m1_reg_addr;
   logic [31:0] m0_reg_wdata, m1_reg_wdata;
   logic [3:0]  m0_reg_be, m1_reg_be;
   logic [31:0] m0_reg_rdata, m1_reg_rdata;
   logic        m0_reg_ack, m0_reg_err, m1_reg_ack, m1_reg_err;
   logic        reg_cs, reg_wr;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   // Bench-side master command storage
   logic        ccs[2];
   logic        cwr[2];
   logic [7:0]  caddr[2];
   logic [31:0] cwdata[2];
   logic [3:0]  cbe[2];

   assign m0_reg_cs    = ccs[0];
   assign m0_reg_wr    = cwr[0];
   assign m0_reg_addr  = caddr[0];
   assign m0_reg_wdata = cwdata[0];
   assign m0_reg_be    = cbe[0];
   assign m1_reg_cs    = ccs[1];
   assign m1_reg_wr    = cwr[1];
   assign m1_reg_addr  = caddr[1];
   assign m1_reg_wdata = cwdata[1];
   assign m1_reg_be    = cbe[1];

   glbl_reg_arb #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR_WORD)) dut (
      .mclk(mclk), .reset(reset),
      .m0_reg_cs(m0_reg_cs), .m0_reg_wr(m0_reg_wr), .m0_reg_addr(m0_reg_addr),
      .m0_reg_wdata(m0_reg_wdata), .m0_reg_be(m0_reg_be),
      .m0_reg_rdata(m0_reg_rdata), .m0_reg_ack(m0_reg_ack), .m0_reg_err(m0_reg_err),
      .m1_reg_cs(m1_reg_cs), .m1_reg_wr(m1_reg_wr), .m1_reg_addr(m1_reg_addr),
      .m1_reg_wdata(m1_reg_wdata), .m1_reg_be(m1_reg_be),
      .m1_reg_rdata(m1_reg_rdata), .m1_reg_ack(m1_reg_ack), .m1_reg_err(m1_reg_err),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
   );

   always #5 mclk = ~mclk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: who won last, and who is still waiting.
   int last_g = 1;
   bit pend[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic set_cmd(input int m, input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      cwr[m] = wr; caddr[m] = a; cwdata[m] = d; cbe[m] = be;
   endtask

   task automatic rand_cmd(input int m);
      set_cmd(m, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
   endtask

   task automatic chk_resp_zero(input string tag);
      chk({tag, "_m0_ack"},   32'(m0_reg_ack), 32'd0);
      chk({tag, "_m1_ack"},   32'(m1_reg_ack), 32'd0);
      chk({tag, "_m0_err"},   32'(m0_reg_err), 32'd0);
      chk({tag, "_m1_err"},   32'(m1_reg_err), 32'd0);
      chk({tag, "_m0_rdata"}, m0_reg_rdata, 32'd0);
      chk({tag, "_m1_rdata"}, m1_reg_rdata, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cs"},    32'(reg_cs), 32'd0);
      chk({tag, "_wr"},    32'(reg_wr), 32'd0);
      chk({tag, "_addr"},  32'(reg_addr), 32'd0);
      chk({tag, "_wdata"}, reg_wdata, 32'd0);
      chk({tag, "_be"},    32'(reg_be), 32'd0);
      chk_resp_zero(tag);
   endtask

   // One complete access. Requests r0/r1 are presented at the IDLE edge; the
   // slave's ack is first visible to the arbiter at edge 'lat' after grant.
   task automatic run_access(input bit r0, input bit r1, input int lat, input logic [31:0] sdata);
      int          g, dur;
      bit          to;
      logic        ewr;
      logic [7:0]  eaddr;
      logic [31:0] ewdata, exp_rd;
      logic [3:0]  ebe;
      ccs[0] = r0;
      ccs[1] = r1;
      g      = (r0 && r1) ? 1 - last_g : (r1 ? 1 : 0);
      ewr = cwr[g]; eaddr = caddr[g]; ewdata = cwdata[g]; ebe = cbe[g];
      to     = (lat > int'(T));
      dur    = to ? int'(T) : lat;
      exp_rd = to ? ERR_WORD : sdata;
      reg_ack = 1'b0;
      tick();
      chk("grant_cs", 32'(reg_cs), 32'd1);
      for (int k = 1; k <= dur; k++) begin
         chk("busy_wr",    32'(reg_wr), 32'(ewr));
         chk("busy_addr",  32'(reg_addr), 32'(eaddr));
         chk("busy_wdata", reg_wdata, ewdata);
         chk("busy_be",    32'(reg_be), 32'(ebe));
         chk_resp_zero("busy");
         reg_ack   = (k == lat);
         reg_rdata = (k == lat) ? sdata : $urandom;
         rand_cmd(g);  // granted master wiggles its inputs; must not reach the slave
         tick();
         if (k < dur) chk("busy_cs", 32'(reg_cs), 32'd1);
      end
      reg_ack = 1'b0;
      chk("resp_cs", 32'(reg_cs), 32'd0);
      chk("resp_m0_ack",   32'(m0_reg_ack), 32'(g == 0));
      chk("resp_m1_ack",   32'(m1_reg_ack), 32'(g == 1));
      chk("resp_m0_err",   32'(m0_reg_err), 32'((g == 0) && to));
      chk("resp_m1_err",   32'(m1_reg_err), 32'((g == 1) && to));
      chk("resp_m0_rdata", m0_reg_rdata, (g == 0) ? exp_rd : 32'd0);
      chk("resp_m1_rdata", m1_reg_rdata, (g == 1) ? exp_rd : 32'd0);
      ccs[g]     = 1'b0;
      pend[g]    = 1'b0;
      pend[1-g]  = (g == 0) ? r1 : r0;
      last_g     = g;
      tick();
      chk("gap_cs", 32'(reg_cs), 32'd0);
      chk_resp_zero("gap");
   endtask

   initial begin
      bit r0, r1;
      reset = 1'b1; reg_ack = 1'b0; reg_rdata = '0;
      for (int m = 0; m < 2; m++) begin
         ccs[m] = 1'b0; pend[m] = 1'b0;
         set_cmd(m, 1'b0, 8'h00, 32'd0, 4'h0);
      end
      tick(); tick();
      chk_all_zero("reset");
      reset = 1'b0;

      // Single read by m0
      set_cmd(0, 1'b0, 8'h00, 32'd0, 4'hF);
      run_access(1'b1, 1'b0, 2, 32'h4433_2211);

      // m1 write
      set_cmd(1, 1'b1, 8'h20, 32'hA5A5_0F0F, 4'b0101);
      run_access(1'b0, 1'b1, 2, $urandom);

      // Both masters request continuously: grants alternate
      rand_cmd(0); rand_cmd(1);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) rand_cmd(last_g);
         run_access(1'b1, 1'b1, 2, $urandom);
      end
      if (pend[0]) begin
         run_access(1'b1, 1'b0, 1, $urandom);
      end
      if (pend[1]) begin
         run_access(1'b0, 1'b1, 1, $urandom);
      end

      // Slave never acks, then a stray late ack is ignored
      rand_cmd(0);
      run_access(1'b1, 1'b0, 100, 32'h0);
      reg_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stray_cs", 32'(reg_cs), 32'd0);
         chk_resp_zero("stray");
      end
      reg_ack = 1'b0;

      // Ack lands on the timeout cycle: ack wins
      rand_cmd(1);
      run_access(1'b0, 1'b1, int'(T), 32'h1234_5678);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         r0 = pend[0] | 1'($urandom);
         r1 = pend[1] | 1'($urandom);
         if (!r0 && !r1) begin
            if ($urandom_range(0, 1) == 0) r0 = 1'b1; else r1 = 1'b1;
         end
         if (r0 && !pend[0]) rand_cmd(0);
         if (r1 && !pend[1]) rand_cmd(1);
         run_access(r0, r1, int'($urandom_range(1, T + 2)), $urandom);
         if (!pend[0] && !pend[1] && ($urandom_range(0, 1) == 1)) begin
            reg_ack = 1'($urandom);
            tick();
            chk("rgap_cs", 32'(reg_cs), 32'd0);
            chk_resp_zero("rgap");
            reg_ack = 1'b0;
         end
      end
      if (pend[0]) run_access(1'b1, 1'b0, 1, $urandom);
      if (pend[1]) run_access(1'b0, 1'b1, 1, $urandom);

      // Reset in the middle of BUSY
      set_cmd(0, 1'b1, 8'h5A, 32'hCAFE_F00D, 4'hF);
      ccs[0] = 1'b1;
      tick();
      chk("rstbusy_cs", 32'(reg_cs), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk_all_zero("rstbusy");
      ccs[0] = 1'b0;
      reset  = 1'b0;
      reg_ack = 1'b1;
      tick();
      chk_all_zero("rstpost");
      reg_ack = 1'b0;
      last_g = 1; pend[0] = 1'b0; pend[1] = 1'b0;
      rand_cmd(0); rand_cmd(1);
      run_access(1'b1, 1'b1, 2, $urandom);
      run_access(1'b0, 1'b1, 2, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
